// File: rtl/graf_pkg.sv
// Shared constants and types for the graffiti drawing pipeline.
package graf_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int COORD_W = 10;
  localparam int ERR_W   = 12;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STEP,
    FINISH
  } li_state_t;

endpackage

// File: rtl/abs_diff_sign.sv
// Magnitude of a-b plus a flag that b lies above a,
// i.e. walking from b to a must decrement.
import graf_pkg::*;

module abs_diff_sign (
  input  logic [COORD_W-1:0] a,
  input  logic [COORD_W-1:0] b,
  output logic [COORD_W-1:0] mag,
  output logic               neg
);

  assign neg = a < b;
  assign mag = neg ? b - a : a - b;

endmodule

// File: rtl/line_interp.sv
// Bresenham walker: joins the previous frame's pen point to the
// current one and streams every pixel on the segment.
import graf_pkg::*;

module line_interp #(
  parameter int H_RES    = graf_pkg::H_RES,
  parameter int V_RES    = graf_pkg::V_RES,
  parameter int MAX_JUMP = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] cam_x,
  input  logic [COORD_W-1:0] cam_y,
  input  logic               cam_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               busy,
  output logic               done,
  output logic               dropped
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

  li_state_t state, state_n;

  logic [COORD_W-1:0] end_x, end_y;
  logic [COORD_W-1:0] prev_x, prev_y;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic               prev_valid;
  logic               single;
  logic               x_dec, y_dec;
  logic signed [ERR_W-1:0] dx, dy, err;

  logic [COORD_W-1:0] adx, ady;
  logic               ndx, ndy;
  logic               jump;
  logic               last;
  logic               step_x, step_y;
  logic signed [ERR_W:0]   e2, dx_w, dy_w;
  logic signed [ERR_W-1:0] err_n;

  abs_diff_sign u_dx (
    .a   (end_x),
    .b   (prev_x),
    .mag (adx),
    .neg (ndx)
  );

  abs_diff_sign u_dy (
    .a   (end_y),
    .b   (prev_y),
    .mag (ady),
    .neg (ndy)
  );

  assign jump = !prev_valid
             || (int'(adx) > MAX_JUMP)
             || (int'(ady) > MAX_JUMP);

  assign last = single || (cur_x == end_x && cur_y == end_y);

  assign e2     = {err, 1'b0};
  assign dx_w   = {dx[ERR_W-1], dx};
  assign dy_w   = {dy[ERR_W-1], dy};
  assign step_x = e2 >= dy_w;
  assign step_y = e2 <= dx_w;
  assign err_n  = err
                + (step_x ? dy : '0)
                + (step_y ? dx : '0);

  assign pix_valid = state == STEP;
  assign busy      = state != IDLE;
  assign pix_x     = cur_x;
  assign pix_y     = cur_y;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (start && cam_valid) state_n = SETUP;
      SETUP:  state_n = STEP;
      STEP:   if (pix_ready && last) state_n = FINISH;
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      end_x      <= '0;
      end_y      <= '0;
      prev_x     <= '0;
      prev_y     <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      prev_valid <= 1'b0;
      single     <= 1'b0;
      x_dec      <= 1'b0;
      y_dec      <= 1'b0;
      dx         <= '0;
      dy         <= '0;
      err        <= '0;
      done       <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      done    <= 1'b0;
      dropped <= start && state != IDLE;
      unique case (state)
        IDLE: if (start) begin
          end_x <= (cam_x > X_MAX) ? X_MAX : cam_x;
          end_y <= (cam_y > Y_MAX) ? Y_MAX : cam_y;
          if (!cam_valid) begin
            prev_valid <= 1'b0;
            done       <= 1'b1;
          end
        end
        SETUP: begin
          single <= jump;
          cur_x  <= jump ? end_x : prev_x;
          cur_y  <= jump ? end_y : prev_y;
          x_dec  <= ndx;
          y_dec  <= ndy;
          dx     <= ERR_W'(adx);
          dy     <= -ERR_W'(ady);
          err    <= ERR_W'(adx) - ERR_W'(ady);
        end
        STEP: if (pix_ready) begin
          if (last) begin
            done <= 1'b1;
          end else begin
            err <= err_n;
            if (step_x) cur_x <= x_dec ? cur_x - 1'b1 : cur_x + 1'b1;
            if (step_y) cur_y <= y_dec ? cur_y - 1'b1 : cur_y + 1'b1;
          end
        end
        FINISH: begin
          prev_x     <= end_x;
          prev_y     <= end_y;
          prev_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_interp.sv
// Scoreboard bench for line_interp: a reference Bresenham model
// queues expected pixels, the monitor checks them as they appear.
module tb_line_interp;

  logic       clk = 0;
  logic       reset = 1;
  logic       start = 0;
  logic [9:0] cam_x = 0;
  logic [9:0] cam_y = 0;
  logic       cam_valid = 0;
  logic       pix_ready = 0;
  logic [9:0] pix_x, pix_y;
  logic       pix_valid, busy, done, dropped;

  line_interp dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cam_x     (cam_x),
    .cam_y     (cam_y),
    .cam_valid (cam_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .busy      (busy),
    .done      (done),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int pop_cnt = 0;
  int ready_mode = 1;
  logic [19:0] q[$];
  int  mpx = 0, mpy = 0;
  bit  mpv = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_pix(input int x, input int y);
    q.push_back({10'(x), 10'(y)});
  endtask

  task automatic model_frame(input int cx, input int cy,
                             input bit v);
    int x1, y1, x, y, dx, dy, sx, sy, err, e2;
    x1 = (cx > 639) ? 639 : cx;
    y1 = (cy > 479) ? 479 : cy;
    if (!v) begin
      mpv = 0;
      return;
    end
    dx = (x1 > mpx) ? x1 - mpx : mpx - x1;
    dy = (y1 > mpy) ? y1 - mpy : mpy - y1;
    if (!mpv || dx > 128 || dy > 128) begin
      push_pix(x1, y1);
    end else begin
      sx = (mpx < x1) ? 1 : -1;
      sy = (mpy < y1) ? 1 : -1;
      dy = -dy;
      err = dx + dy;
      x = mpx;
      y = mpy;
      forever begin
        push_pix(x, y);
        if (x == x1 && y == y1) break;
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; x += sx; end
        if (e2 <= dx) begin err += dx; y += sy; end
      end
    end
    mpx = x1;
    mpy = y1;
    mpv = 1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       pix_ready = 1'b0;
        1:       pix_ready = 1'b1;
        default: pix_ready = ~pix_ready;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (pix_valid) begin
        if (q.size() == 0) begin
          chk("extra_pix", 32'({pix_x, pix_y}), 32'hFFFFF);
        end else begin
          chk("pix", 32'({pix_x, pix_y}), 32'(q[0]));
          if (pix_ready) begin
            void'(q.pop_front());
            pop_cnt++;
          end
        end
      end
    end
  end

  task automatic launch(input int x, input int y, input bit v);
    @(posedge clk);
    #1;
    start = 1;
    cam_x = 10'(x);
    cam_y = 10'(y);
    cam_valid = v;
    model_frame(x, y, v);
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic wait_done(input string tag);
    int d0, t;
    d0 = done_cnt;
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    chk({tag, "_done"}, 32'(done_cnt != d0), 1);
    chk({tag, "_qempty"}, 32'(q.size()), 0);
  endtask

  int p0;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out",
        32'({pix_valid, busy, done, dropped, pix_x, pix_y}), 0);
    @(posedge clk);
    #1 reset = 0;

    launch(100, 50, 1);
    @(negedge clk);
    chk("lat_n1", 32'({busy, pix_valid}), 2);
    @(negedge clk);
    chk("lat_n2", 32'(pix_valid), 1);
    wait_done("pendown");

    p0 = pop_cnt;
    launch(104, 54, 1);
    wait_done("diag");
    chk("diag_len", 32'(pop_cnt - p0), 5);

    launch(10, 10, 1);
    wait_done("back");
    ready_mode = 2;
    p0 = pop_cnt;
    launch(20, 13, 1);
    wait_done("shallow");
    chk("shallow_len", 32'(pop_cnt - p0), 11);
    ready_mode = 1;

    p0 = pop_cnt;
    launch(5, 5, 0);
    wait_done("penup");
    chk("penup_len", 32'(pop_cnt - p0), 0);
    launch(0, 0, 1);
    wait_done("origin");
    p0 = pop_cnt;
    launch(300, 0, 1);
    wait_done("jump");
    chk("jump_len", 32'(pop_cnt - p0), 1);

    launch(700, 500, 1);
    wait_done("clamp");
    ready_mode = 2;
    p0 = pop_cnt;
    launch(600, 479, 1);
    repeat (4) @(posedge clk);
    #1;
    start = 1;
    cam_x = 0;
    cam_y = 0;
    cam_valid = 1;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    chk("dropped", 32'(dropped), 1);
    chk("busy_mid", 32'(busy), 1);
    wait_done("overlap");
    chk("overlap_len", 32'(pop_cnt - p0), 40);

    ready_mode = 0;
    launch(520, 479, 1);
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_valid", 32'({pix_valid, busy}), 0);
    q.delete();
    mpv = 0;
    ready_mode = 1;
    p0 = pop_cnt;
    launch(500, 400, 1);
    wait_done("fresh");
    chk("fresh_len", 32'(pop_cnt - p0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
